// File: rtl/msrv32_pkg.sv
// Shared msrv32 definitions: skid-stage state encoding, default widths and
// a state-to-occupancy helper.
package msrv32_pkg;

  localparam int DEFAULT_PAYLOAD_W = 96;
  localparam int DEFAULT_CTRL_W    = 16;
  localparam int DEFAULT_CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } skid_state_t;

  function automatic logic [1:0] state_occupancy(input skid_state_t st);
    case (st)
      ST_ONE:  return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/msrv32_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module msrv32_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             incr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/msrv32_pipe_stage_skid.sv
// Two-entry skid buffer between pipeline stages with a registered ready,
// flush support and a saturating back-pressure counter.
module msrv32_pipe_stage_skid
  import msrv32_pkg::*;
#(
  parameter int PAYLOAD_W = DEFAULT_PAYLOAD_W,
  parameter int CTRL_W    = DEFAULT_CTRL_W,
  parameter int CNT_W     = DEFAULT_CNT_W
) (
  input  logic                 clk_in,
  input  logic                 reset_n_in,
  input  logic                 in_valid_in,
  output logic                 in_ready_out,
  input  logic [PAYLOAD_W-1:0] in_payload_in,
  input  logic [CTRL_W-1:0]    in_ctrl_in,
  output logic                 out_valid_out,
  input  logic                 out_ready_in,
  output logic [PAYLOAD_W-1:0] out_payload_out,
  output logic [CTRL_W-1:0]    out_ctrl_out,
  input  logic                 flush_in,
  output logic [1:0]           occupancy_out,
  output logic [CNT_W-1:0]     stall_cnt_out
);

  skid_state_t          state;
  logic                 in_ready;
  logic [PAYLOAD_W-1:0] main_payload;
  logic [CTRL_W-1:0]    main_ctrl;
  logic [PAYLOAD_W-1:0] skid_payload;
  logic [CTRL_W-1:0]    skid_ctrl;
  logic                 out_valid;
  logic                 accept;
  logic                 drain;

  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid_in && in_ready;
  assign drain     = out_valid && out_ready_in;

  // in_ready is a flop updated alongside the state, so it never depends
  // combinationally on out_ready_in.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state        <= ST_EMPTY;
      in_ready     <= 1'b1;
      main_payload <= '0;
      main_ctrl    <= '0;
      skid_payload <= '0;
      skid_ctrl    <= '0;
    end else if (flush_in) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_payload <= in_payload_in;
            main_ctrl    <= in_ctrl_in;
            state        <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_payload <= in_payload_in;
            main_ctrl    <= in_ctrl_in;
          end else if (accept) begin
            skid_payload <= in_payload_in;
            skid_ctrl    <= in_ctrl_in;
            state        <= ST_FULL;
            in_ready     <= 1'b0;
          end else if (drain) begin
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            main_payload <= skid_payload;
            main_ctrl    <= skid_ctrl;
            state        <= ST_ONE;
            in_ready     <= 1'b1;
          end
        end
        default: begin
          state    <= ST_EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready_out    = in_ready;
  assign out_valid_out   = out_valid;
  assign out_payload_out = main_payload;
  assign out_ctrl_out    = out_valid ? main_ctrl : '0;
  assign occupancy_out   = state_occupancy(state);

  msrv32_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk_in),
    .rst_n (reset_n_in),
    .clear (flush_in),
    .incr  (out_valid && !out_ready_in),
    .count (stall_cnt_out)
  );

endmodule

// File: tb/tb_msrv32_pipe_stage_skid.sv
// Directed bench for the skid stage; a second instance with CNT_W=4 shares
// all inputs and is used for the counter saturation case.
module tb_msrv32_pipe_stage_skid;
  import msrv32_pkg::*;

  localparam int PW = DEFAULT_PAYLOAD_W;
  localparam int CW = DEFAULT_CTRL_W;
  localparam int NW = DEFAULT_CNT_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic [PW-1:0] in_payload = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;

  logic          in_ready, out_valid;
  logic [PW-1:0] out_payload;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_cnt;

  logic          s_in_ready, s_out_valid;
  logic [PW-1:0] s_out_payload;
  logic [CW-1:0] s_out_ctrl;
  logic [1:0]    s_occupancy;
  logic [3:0]    s_stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msrv32_pipe_stage_skid dut (
    .clk_in(clk), .reset_n_in(rst_n),
    .in_valid_in(in_valid), .in_ready_out(in_ready),
    .in_payload_in(in_payload), .in_ctrl_in(in_ctrl),
    .out_valid_out(out_valid), .out_ready_in(out_ready),
    .out_payload_out(out_payload), .out_ctrl_out(out_ctrl),
    .flush_in(flush), .occupancy_out(occupancy), .stall_cnt_out(stall_cnt)
  );

  msrv32_pipe_stage_skid #(.CNT_W(4)) dut_small (
    .clk_in(clk), .reset_n_in(rst_n),
    .in_valid_in(in_valid), .in_ready_out(s_in_ready),
    .in_payload_in(in_payload), .in_ctrl_in(in_ctrl),
    .out_valid_out(s_out_valid), .out_ready_in(out_ready),
    .out_payload_out(s_out_payload), .out_ctrl_out(s_out_ctrl),
    .flush_in(flush), .occupancy_out(s_occupancy), .stall_cnt_out(s_stall_cnt)
  );

  task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end else begin
      $display("ok   %s value=%0h", tag, obs);
    end
  endtask

  // Outputs are sampled 1ns after the rising edge; inputs change there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [PW-1:0] p, input logic [CW-1:0] c);
    in_valid   = v;
    in_payload = p;
    in_ctrl    = c;
  endtask

  initial begin
    // reset values
    #1 rst_n = 1'b0;
    #2;
    check_value("rst_in_ready", in_ready, 1);
    check_value("rst_out_valid", out_valid, 0);
    check_value("rst_occupancy", occupancy, 0);
    check_value("rst_payload", out_payload, 0);
    check_value("rst_ctrl", out_ctrl, 0);
    check_value("rst_stall", stall_cnt, 0);
    #5 rst_n = 1'b1;
    step();

    // single pass
    out_ready = 1'b1;
    drive(1'b1, 'hA5, 'h3);
    step();
    check_value("single_valid", out_valid, 1);
    check_value("single_payload", out_payload, 'hA5);
    check_value("single_ctrl", out_ctrl, 'h3);
    check_value("single_occ", occupancy, 1);
    drive(1'b0, '0, '0);
    step();
    check_value("single_drained_valid", out_valid, 0);
    check_value("single_drained_ctrl", out_ctrl, 0);

    // back-pressure
    out_ready = 1'b0;
    drive(1'b1, 'h11, 'h1);
    step();
    check_value("bp_occ1", occupancy, 1);
    drive(1'b1, 'h22, 'h2);
    step();
    check_value("bp_occ2", occupancy, 2);
    check_value("bp_ready_low", in_ready, 0);
    check_value("bp_head", out_payload, 'h11);
    drive(1'b1, 'h33, 'h3);
    step();
    check_value("bp_held_occ", occupancy, 2);
    check_value("bp_held_head", out_payload, 'h11);
    check_value("bp_stall", stall_cnt, 2);
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    step();
    check_value("bp_drain2_payload", out_payload, 'h22);
    check_value("bp_drain2_ctrl", out_ctrl, 'h2);
    check_value("bp_drain2_occ", occupancy, 1);
    check_value("bp_drain2_ready", in_ready, 1);
    step();
    check_value("bp_empty_valid", out_valid, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_value("bp_stall_cleared", stall_cnt, 0);

    // streaming 1..100
    out_ready = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      drive(1'b1, PW'(i), CW'(i));
      step();
      check_value($sformatf("stream_%0d", i), {out_valid, out_payload}, {1'b1, PW'(i)});
    end
    drive(1'b0, '0, '0);
    step();
    check_value("stream_stall", stall_cnt, 0);
    check_value("stream_end_valid", out_valid, 0);

    // flush while FULL with a concurrent input
    out_ready = 1'b0;
    drive(1'b1, 'h44, 'h4);
    step();
    drive(1'b1, 'h55, 'h5);
    step();
    check_value("fl_full_occ", occupancy, 2);
    check_value("fl_stall_pre", stall_cnt, 1);
    drive(1'b1, 'h66, 'h6);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    check_value("fl_occ", occupancy, 0);
    check_value("fl_ctrl", out_ctrl, 0);
    check_value("fl_valid", out_valid, 0);
    check_value("fl_stall", stall_cnt, 0);
    check_value("fl_ready", in_ready, 1);
    out_ready = 1'b1;
    step();
    check_value("fl_input_absent", out_valid, 0);

    // saturation on the 4-bit counter instance
    out_ready = 1'b0;
    drive(1'b1, 'h77, 'h7);
    step();
    drive(1'b0, '0, '0);
    for (int i = 0; i < 14; i++) step();
    check_value("sat_small_14", s_stall_cnt, 14);
    for (int i = 0; i < 6; i++) step();
    check_value("sat_small_15", s_stall_cnt, 15);
    check_value("sat_wide_20", stall_cnt, 20);

    // asynchronous reset while FULL, between edges
    drive(1'b1, 'h88, 'h8);
    step();
    drive(1'b0, '0, '0);
    check_value("ar_full_occ", occupancy, 2);
    #2 rst_n = 1'b0;
    #1;
    check_value("ar_in_ready", in_ready, 1);
    check_value("ar_out_valid", out_valid, 0);
    check_value("ar_occ", occupancy, 0);
    check_value("ar_payload", out_payload, 0);
    check_value("ar_ctrl", out_ctrl, 0);
    check_value("ar_stall", stall_cnt, 0);
    check_value("ar_small_stall", s_stall_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check_value("ar_after_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
